// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte FIFOs
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_empty,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_rd,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_din,
  input  logic                    tx_done_tick,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, WAIT} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, pick;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic found, go, more, expire;
  // descending scan so the requester closest after rr_ptr is the last one assigned
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (!req_empty[PW'((int'(rr_ptr) + i) % N_REQ)]) begin
        pick = PW'((int'(rr_ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end
  assign go = en && found;
  assign more = burst_cnt < BURST_LAST && !req_empty[owner] && en;
  assign expire = wait_cnt == WAIT_LAST;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? POP : IDLE;
      POP:     state_nx = LOAD;
      LOAD:    state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = tx_done_tick ? (more ? POP : IDLE) : (expire ? IDLE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    grant = busy ? N_REQ'(1) << owner : '0;
    req_rd = state == POP ? grant : '0;
    tx_start = state == START;
    err_timeout = state == WAIT && !tx_done_tick && expire;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= PW'(N_REQ - 1);
      owner <= '0;
      burst_cnt <= '0;
      wait_cnt <= '0;
      tx_din <= '0;
    end else begin
      if (state == IDLE && go) begin
        rr_ptr <= pick;
        owner <= pick;
        burst_cnt <= '0;
      end
      if (state == LOAD) tx_din <= req_data[owner*DATA_W +: DATA_W];
      if (state == START) wait_cnt <= '0;
      if (state == WAIT) begin
        if (tx_done_tick) burst_cnt <= burst_cnt + 1'b1;
        else wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule
